// File: rtl/typewriter_input_arbiter.sv
// Shares the CPU typewriter-input path between keyboard FIFO and host injection, inserting FIO-DEC case shifts.
// Strobe rises two edges after a request appears in IDLE (one more shift char when case changes); sources wait until granted.
module typewriter_input_arbiter #(
  parameter int GUARD_CYCLES = 2,
  parameter int HOST_BURST   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tty_enable,
  input  logic       kbd_strobe,
  input  logic [6:0] kbd_char,
  output logic       kbd_processed,
  input  logic       host_valid,
  input  logic [6:0] host_char,
  output logic       host_ready,
  output logic       cpu_char_strobe,
  output logic [5:0] cpu_char,
  input  logic       cpu_char_taken,
  output logic       cur_case,
  output logic       busy
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int BW = (HOST_BURST > 0) ? $clog2(HOST_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(HOST_BURST);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [5:0] CODE_UC = 6'o74;
  localparam logic [5:0] CODE_LC = 6'o72;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SHIFT_OUT,
    S_SHIFT_GAP,
    S_CHAR_OUT,
    S_ACK,
    S_GUARD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_hold;
  logic            r_src_host;
  logic            r_last_host;
  logic [BW-1:0]   r_burst;
  logic [GW-1:0]   r_guard;
  logic            r_taken_d;
  logic            r_strobe;
  logic [5:0]      r_char;
  logic            r_case;

  logic            w_taken_rise;
  logic            w_can_arb;
  logic            w_host_keep;
  logic            w_pick_host;
  logic [6:0]      w_src_char;
  logic            w_needs_shift;

  function automatic logic is_shift_code(input logic [5:0] c);
    return (c == CODE_UC) || (c == CODE_LC);
  endfunction

  assign w_taken_rise  = cpu_char_taken & ~r_taken_d & r_strobe;
  assign w_can_arb     = tty_enable && (r_guard == '0);
  // burst is nonzero only after a host grant, so a fresh reset still lets the keyboard win the first tie
  assign w_host_keep   = r_last_host && (r_burst != '0) && (r_burst < BURST_MAX);
  assign w_src_char    = r_src_host ? host_char : kbd_char;
  assign w_needs_shift = !is_shift_code(w_src_char[5:0]) && (w_src_char[6] != r_case);

  always_comb begin
    w_pick_host = 1'b0;
    if (host_valid && !kbd_strobe)
      w_pick_host = 1'b1;
    else if (host_valid && kbd_strobe)
      w_pick_host = w_host_keep || !r_last_host;
  end

  always_comb begin
    w_next        = r_state;
    host_ready    = 1'b0;
    kbd_processed = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_can_arb && (kbd_strobe || host_valid))
          w_next = S_GRANT;
      end
      S_GRANT: begin
        host_ready = r_src_host;
        w_next     = w_needs_shift ? S_SHIFT_OUT : S_CHAR_OUT;
      end
      S_SHIFT_OUT: begin
        if (w_taken_rise)
          w_next = S_SHIFT_GAP;
      end
      S_SHIFT_GAP: w_next = S_CHAR_OUT;
      S_CHAR_OUT: begin
        if (w_taken_rise)
          w_next = S_ACK;
      end
      S_ACK: begin
        kbd_processed = !r_src_host;
        w_next        = S_GUARD;
      end
      S_GUARD: begin
        if (r_guard <= GW'(1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_src_host  <= 1'b0;
      r_last_host <= 1'b1;
      r_burst     <= '0;
      r_guard     <= '0;
      r_taken_d   <= 1'b0;
      r_strobe    <= 1'b0;
      r_char      <= '0;
      r_case      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_taken_d <= cpu_char_taken;
      r_strobe  <= (w_next == S_SHIFT_OUT) || (w_next == S_CHAR_OUT);
      case (r_state)
        S_IDLE: begin
          if (w_next == S_GRANT) begin
            r_src_host <= w_pick_host;
            if (!w_pick_host)
              r_burst <= '0;
            else if (r_burst != BURST_MAX)
              r_burst <= r_burst + 1'b1;
          end
        end
        S_GRANT: begin
          r_hold <= w_src_char;
          if (w_needs_shift)
            r_char <= w_src_char[6] ? CODE_UC : CODE_LC;
          else
            r_char <= w_src_char[5:0];
        end
        S_SHIFT_OUT: begin
          if (w_taken_rise)
            r_case <= r_hold[6];
        end
        S_SHIFT_GAP: r_char <= r_hold[5:0];
        S_CHAR_OUT: begin
          if (w_taken_rise) begin
            if (r_hold[5:0] == CODE_UC)
              r_case <= 1'b1;
            else if (r_hold[5:0] == CODE_LC)
              r_case <= 1'b0;
          end
        end
        S_ACK: begin
          r_last_host <= r_src_host;
          r_guard     <= GUARD_LOAD;
        end
        S_GUARD: begin
          if (r_guard != '0)
            r_guard <= r_guard - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_char_strobe = r_strobe;
  assign cpu_char        = r_char;
  assign cur_case        = r_case;

  a_ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(host_ready && kbd_processed));
  a_strobe_in_out_state: assert property (@(posedge clk) disable iff (!reset_n)
    cpu_char_strobe |-> (r_state == S_SHIFT_OUT || r_state == S_CHAR_OUT));
  a_burst_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    r_burst <= BURST_MAX);

endmodule

// File: tb/tb_typewriter_input_arbiter.sv
// Randomised scoreboard bench: a sequence-level model predicts grant order and CPU character stream.
module tb_typewriter_input_arbiter;
  localparam int GUARD_CYCLES = 2;
  localparam int HOST_BURST   = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tty_enable = 1'b0;
  logic       kbd_strobe = 1'b0;
  logic [6:0] kbd_char = '0;
  logic       kbd_processed;
  logic       host_valid = 1'b0;
  logic [6:0] host_char = '0;
  logic       host_ready;
  logic       cpu_char_strobe;
  logic [5:0] cpu_char;
  logic       cpu_char_taken = 1'b0;
  logic       cur_case;
  logic       busy;

  typewriter_input_arbiter #(.GUARD_CYCLES(GUARD_CYCLES), .HOST_BURST(HOST_BURST)) dut (
    .clk(clk), .reset_n(reset_n), .tty_enable(tty_enable),
    .kbd_strobe(kbd_strobe), .kbd_char(kbd_char), .kbd_processed(kbd_processed),
    .host_valid(host_valid), .host_char(host_char), .host_ready(host_ready),
    .cpu_char_strobe(cpu_char_strobe), .cpu_char(cpu_char), .cpu_char_taken(cpu_char_taken),
    .cur_case(cur_case), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] kbd_q[$];
  logic [6:0] host_q[$];
  logic [6:0] st_k[$];
  logic [6:0] st_h[$];
  logic [5:0] exp_q[$];
  bit         exp_src[$];

  bit m_case;
  bit m_last_host;
  int m_burst;

  int ack_min = 0;
  int ack_max = 3;
  int cyc = 0;
  int kbd_pulses = 0;
  int kp_width = 0;
  int t_req = 0;
  bit lat_armed = 0;
  bit pend_host = 0;
  int cpu_st = 0;
  int cpu_dly = 0;
  bit mon_prev_strobe = 0;
  bit mon_prev_kbd = 0;
  logic [5:0] mon_exp;
  bit mon_src;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_case = 1'b0;
    m_last_host = 1'b1;
    m_burst = 0;
  endtask

  // Case handling: explicit shift codes set the case; other codes get a shift prefix when their case differs.
  task automatic model_emit(input logic [6:0] c);
    if (c[5:0] == 6'o72 || c[5:0] == 6'o74) begin
      exp_q.push_back(c[5:0]);
      m_case = (c[5:0] == 6'o74);
    end else begin
      if (c[6] != m_case) begin
        exp_q.push_back(c[6] ? 6'o74 : 6'o72);
        m_case = c[6];
      end
      exp_q.push_back(c[5:0]);
    end
  endtask

  // Sources hold their whole load from the start, so each decision sees "both pending" until one list runs dry.
  task automatic model_run();
    int ki = 0;
    int hi = 0;
    bit host;
    while (ki < st_k.size() || hi < st_h.size()) begin
      if (ki < st_k.size() && hi < st_h.size())
        host = m_last_host ? (m_burst > 0 && m_burst < HOST_BURST) : 1'b1;
      else
        host = (hi < st_h.size());
      exp_src.push_back(host);
      if (host) begin
        model_emit(st_h[hi]);
        hi++;
        if (m_burst < HOST_BURST) m_burst++;
      end else begin
        model_emit(st_k[ki]);
        ki++;
        m_burst = 0;
      end
      m_last_host = host;
    end
  endtask

  task automatic start_scn(input bit push_kbd);
    model_run();
    if (push_kbd) foreach (st_k[i]) kbd_q.push_back(st_k[i]);
    foreach (st_h[i]) host_q.push_back(st_h[i]);
    st_k.delete();
    st_h.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || kbd_q.size() != 0 || host_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d chars still pending after %0d cycles", name, exp_q.size(), n);
    end
    check({name, "_cur_case"}, cur_case, m_case);
    check({name, "_grants_left"}, exp_src.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // keyboard FIFO and host stream models
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      pend_host = 0;
    end else begin
      if (pend_host && host_q.size() != 0) void'(host_q.pop_front());
      pend_host = 0;
      if (kbd_processed && kbd_q.size() != 0) void'(kbd_q.pop_front());
      if (host_valid && host_ready) pend_host = 1;
    end
    kbd_strobe = (kbd_q.size() != 0);
    kbd_char   = (kbd_q.size() != 0) ? kbd_q[0] : 7'd0;
    host_valid = (host_q.size() != 0);
    host_char  = (host_q.size() != 0) ? host_q[0] : 7'd0;
  end

  // CPU side: acknowledge each strobe after a programmable delay, release after it drops
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      cpu_char_taken = 1'b0;
      cpu_st = 0;
    end else begin
      case (cpu_st)
        0: if (cpu_char_strobe && !cpu_char_taken) begin
             cpu_dly = $urandom_range(ack_max, ack_min);
             cpu_st = 1;
           end
        1: if (cpu_dly == 0) begin cpu_char_taken = 1'b1; cpu_st = 2; end else cpu_dly--;
        2: if (!cpu_char_strobe) begin cpu_dly = $urandom_range(2, 0); cpu_st = 3; end
        3: if (cpu_dly == 0) begin cpu_char_taken = 1'b0; cpu_st = 0; end else cpu_dly--;
        default: cpu_st = 0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every strobe rise and every source acknowledge
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (kbd_strobe && !mon_prev_kbd) t_req = cyc;
      if (cpu_char_strobe && !mon_prev_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cpu_char_unexpected: got %0o with nothing expected", cpu_char);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cpu_char", cpu_char, mon_exp);
        end
        if (lat_armed) begin
          check("req_to_strobe_latency", cyc - t_req, 2);
          lat_armed = 0;
        end
      end
      if ((host_valid && host_ready) || (kbd_processed && kp_width == 0)) begin
        if (exp_src.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_unexpected: source host=%0d with no grant expected", host_ready);
        end else begin
          mon_src = exp_src.pop_front();
          check("grant_source_is_host", host_ready, mon_src);
        end
      end
      if (kbd_processed) begin
        if (kp_width == 0) kbd_pulses++;
        kp_width++;
      end else if (kp_width != 0) begin
        check("kbd_processed_width", kp_width, 1);
        kp_width = 0;
      end
    end else begin
      kp_width = 0;
    end
    mon_prev_strobe = reset_n && cpu_char_strobe;
    mon_prev_kbd    = reset_n && kbd_strobe;
  end

  initial begin
    int n;
    bit saw;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_strobe", cpu_char_strobe, 0);
    check("rst_cpu_char", cpu_char, 0);
    check("rst_kbd_processed", kbd_processed, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_cur_case", cur_case, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    tty_enable = 1'b1;

    // single lower-case keyboard char, fixed CPU latency
    ack_min = 3; ack_max = 3;
    kbd_pulses = 0;
    lat_armed = 1;
    st_k.push_back({1'b0, 6'o61});
    start_scn(1);
    drain("t1", 400);
    check("t1_kbd_pulses", kbd_pulses, 1);

    // case change up then down
    st_k.push_back({1'b1, 6'o61});
    start_scn(1);
    drain("t2a", 400);
    check("t2a_upper", cur_case, 1);
    st_k.push_back({1'b0, 6'o62});
    start_scn(1);
    drain("t2b", 400);

    // host burst against a held keyboard request
    ack_min = 0; ack_max = 2;
    kbd_pulses = 0;
    for (int i = 0; i < 20; i++) st_h.push_back(7'($urandom_range(0, 127)));
    for (int i = 0; i < 3; i++) st_k.push_back(7'($urandom_range(0, 127)));
    start_scn(1);
    drain("t3", 5000);
    check("t3_kbd_pulses", kbd_pulses, 3);

    // explicit upper-case shift from the host, no inserted shift
    st_h.push_back({1'b0, 6'o74});
    st_h.push_back({1'b1, 6'o25});
    start_scn(1);
    drain("t4", 400);
    check("t4_upper", cur_case, 1);

    // tty disabled: nothing granted; dropping it mid-character finishes only that character
    @(negedge clk);
    tty_enable = 1'b0;
    st_k.push_back({m_case, 6'o61});
    st_h.push_back({m_case, 6'o62});
    start_scn(1);
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      saw |= busy | host_ready | cpu_char_strobe;
    end
    check("t5_no_grant_disabled", saw, 0);
    tty_enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_char_strobe && n < 50);
    check("t5_strobe_seen", cpu_char_strobe, 1);
    tty_enable = 1'b0;
    repeat (40) @(negedge clk);
    check("t5_outputs_left", exp_q.size(), 1);
    check("t5_grants_left", exp_src.size(), 1);
    check("t5_idle_busy", busy, 0);
    tty_enable = 1'b1;
    drain("t5", 400);

    // reset during shift output; keyboard char then re-sent, and it wins the first tie
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    ack_min = 6; ack_max = 6;
    st_k.push_back({1'b1, 6'o61});
    start_scn(1);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_char_strobe && n < 50);
    check("t6_shift_strobe", cpu_char_strobe, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_strobe_dropped", cpu_char_strobe, 0);
    check("t6_no_kbd_ack", kbd_processed, 0);
    check("t6_case_cleared", cur_case, 0);
    check("t6_busy", busy, 0);
    exp_q.delete();
    exp_src.delete();
    model_reset();
    st_k.push_back({1'b1, 6'o61});
    st_h.push_back({1'b0, 6'o13});
    st_h.push_back({1'b1, 6'o44});
    start_scn(0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ack_min = 0; ack_max = 3;
    drain("t6", 600);

    // randomised mixes
    for (int r = 0; r < 6; r++) begin
      ack_min = 0;
      ack_max = $urandom_range(4, 0);
      for (int i = 0; i < $urandom_range(4, 0); i++) st_k.push_back(7'($urandom_range(0, 127)));
      for (int i = 0; i < $urandom_range(10, 0); i++) st_h.push_back(7'($urandom_range(0, 127)));
      start_scn(1);
      drain("rnd", 5000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/typewriter_input_arbiter.md
Name: typewriter_input_arbiter

Overview:
Sits between the console keyboard block and the CPU typewriter-input (tyi) path. It shares that single path between two sources: the keyboard FIFO, and a host text-injection stream (OSD paste / file-to-typewriter). It tracks the FIO-DEC upper/lower case state of the typewriter and inserts a shift code (074 upper, 072 lower) whenever the next character's case differs from the current case. It then presents one 6-bit character at a time to the CPU with a level-strobe handshake.

Parameters:
GUARD_CYCLES, 2, idle cycles after a source acknowledge before the next arbitration; covers the keyboard FIFO's one-cycle output lag.
HOST_BURST, 8, maximum consecutive host grants while the keyboard is requesting; 0 means plain round robin.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tty_enable  in  1  high when the output device is the teletype; gates new grants only
kbd_strobe  in  1  keyboard has a character pending (level)
kbd_char  in  7  {case, fiodec[5:0]} from the keyboard FIFO head
kbd_processed  out  1  one-cycle pulse; keyboard advances its read pointer on the rising edge
host_valid  in  1  host character available
host_char  in  7  {case, fiodec[5:0]}
host_ready  out  1  host transfer occurs on the cycle host_valid & host_ready is high
cpu_char_strobe  out  1  character available to the CPU (level)
cpu_char  out  6  FIO-DEC code presented to the CPU
cpu_char_taken  in  1  CPU consumed the character; rising edge detected internally
cur_case  out  1  current typewriter case, 1 = upper
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs 0.
  - last_grant = HOST, so the keyboard wins the first tie.
  - Burst counter, guard counter and taken-edge register cleared.
  - An in-flight character is dropped, with no ack to either source.
- States: IDLE, GRANT, SHIFT_OUT, SHIFT_GAP, CHAR_OUT, ACK, GUARD.
- IDLE:
  - Arbitrates only when tty_enable=1 and the guard count is 0.
  - Requests are kbd_strobe and host_valid.
  - Single requester: that source wins.
  - Both requesting: the source other than last_grant wins, except that the host keeps the grant while burst_cnt < HOST_BURST.
  - burst_cnt increments on each host grant and clears on each keyboard grant.
- GRANT (1 cycle):
  - The char is latched into a 7-bit hold register.
  - Host: host_ready=1 this cycle only.
  - Keyboard: no output this cycle.
  - Next state: CHAR_OUT if the code is 072 or 074, or if hold case == cur_case; otherwise SHIFT_OUT.
- SHIFT_OUT:
  - cpu_char = 074 if hold case = 1, else 072; cpu_char_strobe=1.
  - On the taken rising edge, cur_case <= hold case, strobe drops next cycle, state goes to SHIFT_GAP.
- SHIFT_GAP (1 cycle): strobe=0, then CHAR_OUT. This gives the CPU a visible strobe edge.
- CHAR_OUT:
  - cpu_char = hold[5:0], strobe=1.
  - An explicit 074 sets cur_case to 1 on its taken edge; an explicit 072 sets it to 0.
  - On the taken edge, go to ACK.
- ACK (1 cycle):
  - Strobe=0.
  - kbd_processed=1 if the keyboard was the grantee; the host was already acknowledged in GRANT.
  - last_grant is updated, guard count is loaded with GUARD_CYCLES, then GUARD.
- GUARD: decrement to 0, then IDLE.
- Latency: request in IDLE at edge k → strobe high from edge k+2 when no shift is needed.
- The strobe is registered and never toggles within a state.
- tty_enable falling mid-sequence: the current sequence completes; no new grant follows.
- Simultaneous taken edge and state entry: taken is sampled only while strobe=1. An edge arriving during GRANT, SHIFT_GAP or ACK is ignored.
- A taken level held high across SHIFT_GAP does not count as a new edge. A fresh rising edge is required for CHAR_OUT.
- No source is starved: with both requesting, the keyboard is granted within HOST_BURST+1 grants.
- Widths: burst_cnt holds HOST_BURST without wrap; the guard counter is ceil(log2(GUARD_CYCLES+1)) bits.

Test Plan:
1. Reset, then keyboard char {0,061} ('a'), CPU acks each strobe 3 cycles after it rises. Required: a single strobe with cpu_char=061, one kbd_processed pulse, cur_case stays 0.
2. Keyboard char {1,061}. Required: strobe with 074, gap cycle, strobe with 061, cur_case=1; then {0,062} produces 072 followed by 062.
3. Host streams 20 chars while keyboard_strobe is held high, HOST_BURST=8. Required: grant order is H×8, K, H×8, K, …, and each keyboard grant produces exactly one kbd_processed pulse.
4. Host sends explicit 074 followed by {1,025}. Required: 074 then 025 with no inserted shift, cur_case=1.
5. tty_enable=0 with both sources requesting. Required: no grant, busy=0. Drop tty_enable during CHAR_OUT: the char completes, then no further grant.
6. Assert reset_n=0 during SHIFT_OUT. Required: strobe drops immediately, no ack pulse, cur_case=0; after release the keyboard char is re-sent from scratch.
